// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences a multi-cycle divider and owns the architectural HI/LO registers
module div_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             DivCtrl,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             DivDone,
  input  logic             Div0,
  input  logic [WIDTH-1:0] DivHIOut,
  input  logic [WIDTH-1:0] DivLOOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0_exc,
  input  logic             exc_clr
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] REARM = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_div_a, r_div_b, r_hi, r_lo;
  logic             r_done, r_exc;
  logic             w_idle, w_run, w_rearm, w_accept, w_fin, w_abort, w_wr;
  assign w_idle   = r_state == IDLE;
  assign w_run    = r_state == RUN;
  assign w_rearm  = r_state == REARM;
  assign w_accept = w_idle & start;
  assign w_abort  = w_run & flush;
  assign w_fin    = w_run & DivDone & ~flush;
  assign w_wr     = w_idle & ~start;
  assign DivCtrl  = w_run;
  assign busy     = w_run | w_rearm;
  assign done     = r_done;
  assign div0_exc = r_exc;
  assign div_a    = r_div_a;
  assign div_b    = r_div_b;
  assign hi       = r_hi;
  assign lo       = r_lo;
  // state, operand latch, HI/LO update and sticky divide-by-zero flag; done marks only completed REARMs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_div_a <= '0;
      r_div_b <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_accept ? RUN : (w_fin | w_abort) ? REARM : w_run ? RUN : IDLE;
      r_done  <= w_fin;
      r_div_a <= w_accept ? op_a : r_div_a;
      r_div_b <= w_accept ? op_b : r_div_b;
      r_hi    <= (w_fin & ~Div0) ? DivHIOut : (w_wr & hi_we) ? wdata : r_hi;
      r_lo    <= (w_fin & ~Div0) ? DivLOOut : (w_wr & lo_we) ? wdata : r_lo;
      r_exc   <= (w_fin & Div0) | (r_exc & ~exc_clr & ~w_accept);
    end
  end
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: randomized self-checking bench with a behavioural divider and HI/LO model
module tb_div_hilo_ctrl;
  logic        clock = 0, reset = 0, start = 0, flush = 0, hi_we = 0, lo_we = 0, exc_clr = 0;
  logic        DivDone = 0, Div0 = 0;
  logic [31:0] op_a = 0, op_b = 0, wdata = 0, DivHIOut = 0, DivLOOut = 0;
  logic        DivCtrl, busy, done, div0_exc;
  logic [31:0] div_a, div_b, hi, lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic        m_exc = 0;
  int          checks = 0, errors = 0;

  div_hilo_ctrl #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .DivCtrl(DivCtrl), .div_a(div_a), .div_b(div_b),
    .DivDone(DivDone), .Div0(Div0), .DivHIOut(DivHIOut), .DivLOOut(DivLOOut),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0_exc(div0_exc), .exc_clr(exc_clr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({DivCtrl, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle ctl/busy/done got %b exp 000", name, {DivCtrl, busy, done});
    end
    checks++;
    if ({hi, lo, div0_exc} !== {m_hi, m_lo, m_exc}) begin
      errors++;
      $display("FAIL %s hi/lo/exc got %h %h %b exp %h %h %b", name, hi, lo, div0_exc, m_hi, m_lo, m_exc);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 1; hi_we = 1; wdata = 32'h5555_5555; op_a = 32'h77;
    tick(); tick();
    reset = 0; start = 0; hi_we = 0;
    m_hi = 0; m_lo = 0; m_exc = 0;
    checks++;
    if ({div_a, div_b} !== 64'd0) begin
      errors++;
      $display("FAIL reset div_a/div_b got %h %h exp 0 0", div_a, div_b);
    end
    check_idle("reset");
  endtask

  // launch a division, let the bench-side divider answer after lat cycles
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b, input int lat, input logic clr);
    start = 1; op_a = a; op_b = b;
    tick();
    start = 0; op_a = $urandom; op_b = $urandom; m_exc = 0;
    checks++;
    if ({DivCtrl, busy, done, div0_exc, div_a, div_b} !== {4'b1100, a, b}) begin
      errors++;
      $display("FAIL %s launch ctl/busy/done/exc/a/b got %b%b%b%b %h %h exp 1100 %h %h", name, DivCtrl, busy, done, div0_exc, div_a, div_b, a, b);
    end
    for (int i = 0; i < lat; i++) begin
      start = 1; op_a = 32'd9;
      tick();
      start = 0;
      checks++;
      if ({DivCtrl, done, div_a, div_b} !== {2'b10, a, b}) begin
        errors++;
        $display("FAIL %s run cyc %0d ctl/done/a/b got %b%b %h %h exp 10 %h %h", name, i, DivCtrl, done, div_a, div_b, a, b);
      end
    end
    DivDone = 1; Div0 = (div_b == 0); exc_clr = clr;
    if (div_b == 0) begin
      DivHIOut = $urandom; DivLOOut = $urandom;
    end else begin
      DivHIOut = $signed(div_a) % $signed(div_b); DivLOOut = $signed(div_a) / $signed(div_b);
    end
    tick();
    DivDone = 0; Div0 = 0; exc_clr = 0;
    if (b == 0) m_exc = 1;
    else begin
      m_hi = $signed(a) % $signed(b); m_lo = $signed(a) / $signed(b);
    end
    checks++;
    if ({DivCtrl, busy, done} !== 3'b011) begin
      errors++;
      $display("FAIL %s rearm ctl/busy/done got %b exp 011", name, {DivCtrl, busy, done});
    end
    checks++;
    if ({hi, lo, div0_exc} !== {m_hi, m_lo, m_exc}) begin
      errors++;
      $display("FAIL %s result hi/lo/exc got %h %h %b exp %h %h %b", name, hi, lo, div0_exc, m_hi, m_lo, m_exc);
    end
    tick();
    check_idle(name);
  endtask

  task automatic test_basic();
    run_div("case1", 32'd100, 32'd7, 3, 1'b0);
    checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL case1 const hi/lo got %0d %0d exp 2 14", hi, lo);
    end
  endtask

  task automatic test_div0();
    run_div("case2", 32'd5, 32'd0, 2, 1'b1);
    exc_clr = 1;
    tick();
    exc_clr = 0; m_exc = 0;
    check_idle("case2_clr");
  endtask

  task automatic test_hilo_write();
    hi_we = 1; wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 0; m_hi = 32'hDEAD_BEEF;
    check_idle("case3_hi");
    lo_we = 1; wdata = 32'h0BAD_F00D;
    tick();
    lo_we = 0; m_lo = 32'h0BAD_F00D;
    check_idle("case3_lo");
    start = 1; op_a = 32'd50; op_b = 32'd4; hi_we = 1; lo_we = 1; wdata = 32'h1111_2222;
    tick();
    start = 0; hi_we = 1; lo_we = 1; wdata = 32'h3333_4444;
    tick();
    hi_we = 0; lo_we = 0;
    checks++;
    if ({busy, hi, lo} !== {1'b1, m_hi, m_lo}) begin
      errors++;
      $display("FAIL case3_busy busy/hi/lo got %b %h %h exp 1 %h %h", busy, hi, lo, m_hi, m_lo);
    end
    flush = 1;
    tick();
    flush = 0;
    tick();
    check_idle("case3_end");
  endtask

  task automatic test_flush();
    start = 1; op_a = -32'sd20; op_b = 32'd3;
    tick();
    start = 0;
    tick(); tick();
    flush = 1; DivDone = 1; DivHIOut = 32'hAAAA; DivLOOut = 32'hBBBB;
    tick();
    flush = 0; DivDone = 0;
    checks++;
    if ({DivCtrl, busy, done, hi, lo} !== {3'b010, m_hi, m_lo}) begin
      errors++;
      $display("FAIL case4_flush ctl/busy/done hi lo got %b %h %h exp 010 %h %h", {DivCtrl, busy, done}, hi, lo, m_hi, m_lo);
    end
    flush = 1;
    tick();
    flush = 0;
    check_idle("case4_after");
    DivDone = 1; DivHIOut = 32'h1234;
    tick();
    DivDone = 0;
    check_idle("ignored_done");
    run_div("case4_redo", -32'sd20, 32'd3, 1, 1'b0);
    checks++;
    if ({hi, lo} !== {-32'sd2, -32'sd6}) begin
      errors++;
      $display("FAIL case4 const hi/lo got %h %h exp fffffffe fffffffa", hi, lo);
    end
  endtask

  task automatic test_restart_ignored();
    run_div("case5", 32'd40, 32'd6, 4, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    start = 1; op_a = 32'd1000; op_b = 32'd3;
    tick();
    start = 0;
    tick();
    reset = 1;
    tick();
    reset = 0; m_hi = 0; m_lo = 0; m_exc = 0;
    checks++;
    if ({div_a, div_b} !== 64'd0) begin
      errors++;
      $display("FAIL case6 div_a/div_b got %h %h exp 0 0", div_a, div_b);
    end
    check_idle("case6_reset");
    run_div("case6_after", 32'd1000, 32'd3, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      run_div("rand", a, b, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1)); wdata = $urandom;
        tick();
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        hi_we = 0; lo_we = 0;
        check_idle("rand_wr");
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_div0();
    test_hilo_write();
    test_flush();
    test_restart_ignored();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
